// File: rtl/pool_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the streaming 2-D pooling block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pool_pkg;

    // Pooling operation selector; 2'b11 behaves as max.
    typedef enum logic [1:0] {
        MODE_MAX  = 2'b00,
        MODE_MIN  = 2'b01,
        MODE_AVG  = 2'b10,
        MODE_MAX2 = 2'b11
    } pool_mode_e;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } pool_state_e;

    // Accumulator width that holds the sum of ksize*ksize pixels without overflow.
    function automatic int sum_width(input int width, input int ksize);
        return width + $clog2(ksize * ksize);
    endfunction

endpackage

// File: rtl/pool_window_reduce.sv
`timescale 1ns/1ps
// Combinational max / min / floor-average over one KSIZE x KSIZE window.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
//
// Ports:
//   i_mode  pooling operation for this window
//   i_win   KSIZE*KSIZE pixels packed, pixel k at bits [k*WIDTH +: WIDTH]
//   o_res   reduced pixel
module pool_window_reduce
    import pool_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KSIZE = 3
)
(
    input  pool_mode_e                   i_mode,
    input  logic [KSIZE*KSIZE*WIDTH-1:0] i_win,
    output logic [WIDTH-1:0]             o_res
);

    localparam int NPIX = KSIZE * KSIZE;
    localparam int SW   = sum_width(WIDTH, KSIZE);

    logic [WIDTH-1:0] w_max;
    logic [WIDTH-1:0] w_min;
    logic [SW-1:0]    w_sum;

    always_comb begin
        w_max = i_win[WIDTH-1:0];
        w_min = i_win[WIDTH-1:0];
        w_sum = '0;
        for (int k = 0; k < NPIX; k++) begin
            if (i_win[k*WIDTH +: WIDTH] > w_max) w_max = i_win[k*WIDTH +: WIDTH];
            if (i_win[k*WIDTH +: WIDTH] < w_min) w_min = i_win[k*WIDTH +: WIDTH];
            w_sum = w_sum + SW'(i_win[k*WIDTH +: WIDTH]);
        end
    end

    // The floor average of WIDTH-bit pixels always fits in WIDTH bits.
    always_comb begin
        case (i_mode)
            MODE_MIN: o_res = w_min;
            MODE_AVG: o_res = WIDTH'(w_sum / SW'(NPIX));
            default:  o_res = w_max;
        endcase
    end

endmodule

// File: rtl/stream_pool2d.sv
`timescale 1ns/1ps
// Streaming stride-1 KSIZE x KSIZE pooling over a raster-order ROWSIZE x COLSIZE frame.
// Latency: result valid 1 cycle after the pixel that completes its window is accepted.
// Backpressure: in_ready = !out_valid || out_ready (forced low in FLUSH); output held while stalled.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mode                       00 max, 01 min, 10 average, 11 max; sampled on pixel 0
//   in_data/in_valid/in_ready  pixel input stream
//   out_data/out_valid/out_ready/out_last  pooled output stream, out_last on final window
//   busy                       frame in progress (first pixel accepted .. last output accepted)
module stream_pool2d
    import pool_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ROWSIZE = 5,
    parameter int COLSIZE = 5,
    parameter int KSIZE   = 3
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = (COLSIZE > 1) ? $clog2(COLSIZE) : 1;
    localparam int RW = (ROWSIZE > 1) ? $clog2(ROWSIZE) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLSIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWSIZE - 1);
    localparam logic [CW-1:0] COL_K    = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_K    = RW'(KSIZE - 1);

    pool_state_e      r_state;
    pool_state_e      w_state_nxt;
    pool_mode_e       r_mode;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic             r_out_valid;
    logic             r_out_last;
    logic [WIDTH-1:0] r_out_data;

    // r_lb[j][c] holds the pixel of row (current-1-j) at column c.
    logic [WIDTH-1:0] r_lb  [KSIZE-1][COLSIZE];
    logic [WIDTH-1:0] r_win [KSIZE][KSIZE];

    logic [WIDTH-1:0]             w_col_vec  [KSIZE];
    logic [WIDTH-1:0]             w_next_win [KSIZE][KSIZE];
    logic [KSIZE*KSIZE*WIDTH-1:0] w_win_flat;
    logic [WIDTH-1:0]             w_res;
    logic                         w_accept;
    logic                         w_out_fire;
    logic                         w_frame_last;
    logic                         w_win_done;

    assign in_ready     = (r_state != ST_FLUSH) && (!r_out_valid || out_ready);
    assign w_accept     = in_valid && in_ready;
    assign w_out_fire   = r_out_valid && out_ready;
    assign w_frame_last = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_win_done   = (r_row >= ROW_K) && (r_col >= COL_K);

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign busy      = (r_state != ST_IDLE);

    // New window column: current pixel at the bottom, older rows above it.
    // The window includes the incoming pixel so the result is ready one cycle later.
    always_comb begin
        for (int i = 0; i < KSIZE; i++) w_col_vec[i] = '0;
        w_col_vec[KSIZE-1] = in_data;
        for (int j = 0; j < KSIZE-1; j++) w_col_vec[KSIZE-2-j] = r_lb[j][r_col];
        w_win_flat = '0;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                w_next_win[i][j] = (j < KSIZE-1) ? r_win[i][j+1] : w_col_vec[i];
                w_win_flat[(i*KSIZE+j)*WIDTH +: WIDTH] = w_next_win[i][j];
            end
        end
    end

    pool_window_reduce #(
        .WIDTH (WIDTH),
        .KSIZE (KSIZE)
    ) u_reduce (
        .i_mode (r_mode),
        .i_win  (w_win_flat),
        .o_res  (w_res)
    );

    // Pixel storage is never reset: a window is only emitted once every slot
    // has been rewritten by the current frame.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb[0][r_col] <= in_data;
            for (int j = 1; j < KSIZE-1; j++) r_lb[j][r_col] <= r_lb[j-1][r_col];
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) r_win[i][j] <= w_next_win[i][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_mode      <= MODE_MAX;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_accept) begin
                if (w_frame_last) begin
                    r_col <= '0;
                    r_row <= '0;
                end else if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                if (r_state == ST_IDLE) r_mode <= pool_mode_e'(mode);
            end
            // A completing pixel can only be accepted when the output slot is
            // free or draining this cycle, so loading here never drops a result.
            if (w_accept && w_win_done) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_frame_last;
                r_out_data  <= w_res;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = w_frame_last ? ST_FLUSH : ST_RUN;
            ST_RUN:   if (w_accept && w_frame_last) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_out_fire && r_out_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
